gray_conv_arbiter: RTL and testbench

//  Shares one registered binary<->Gray converter among NREQ requesters.

---
 rtl/gray_conv_arbiter.sv | 150 +++++++++++++++
 tb/tb_gray_conv_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   One registered binary<->Gray converter shared by NREQ requesters.
//   A round-robin arbiter picks one valid requester per cycle. The converted
//   code lands in a single-entry output stage tagged with requester id and mode.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester request valid            [NREQ]
//   req_data   requester i at [i*WIDTH +: WIDTH]       [NREQ*WIDTH]
//   req_mode   per-requester 0 = bin->Gray, 1 = Gray->bin
//   req_ready  one-hot grant (combinational)           [NREQ]
//   out_valid  output stage holds a result
//   out_ready  consumer accepts the result
//   out_data   converted code                          [WIDTH]
//   out_id     requester that produced out_data        [IDW]
//   out_mode   mode used for out_data
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_mode
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic             mode_reg, mode_next;

  logic [WIDTH-1:0] req_word [NREQ];
  logic [IDW-1:0]   scan_idx [NREQ];
  logic [NREQ-1:0]  scan_valid;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             grant_valid;
  logic             can_accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic [WIDTH-1:0] conv_data;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Slot gi of the scan looks at requester (ptr + gi) mod NREQ, so slot 0
  // always holds the highest-priority requester for this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      localparam logic [IDW:0]   OFFSET = (IDW+1)'(gi);
      localparam logic [IDW-1:0] SELF   = IDW'(gi);
      logic [IDW:0] sum;
      logic [IDW:0] wrapped;

      assign req_word[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign sum            = {1'b0, ptr_reg} + OFFSET;
      assign wrapped        = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
      assign scan_idx[gi]   = wrapped[IDW-1:0];
      assign scan_valid[gi] = req_valid[scan_idx[gi]];
      assign req_ready[gi]  = grant_valid && (grant_idx == SELF);
    end
  endgenerate

  // Lowest scan slot with a valid request wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (scan_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
  end

  // FULL only frees up when the consumer pops in the same cycle. Grants are
  // masked during reset so req_ready reads zero for the whole reset window.
  assign can_accept  = (state_reg == EMPTY) || out_ready;
  assign grant_valid = grant_found && can_accept && !rst;

  assign sel_data  = req_word[grant_idx];
  assign sel_mode  = req_mode[grant_idx];
  assign conv_data = sel_mode ? gray2bin(sel_data) : bin2gray(sel_data);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    id_next    = id_reg;
    mode_next  = mode_reg;
    if (grant_valid) begin
      // Covers both the EMPTY fill and the FULL pop+push replacement.
      data_next  = conv_data;
      id_next    = grant_idx;
      mode_next  = sel_mode;
      state_next = FULL;
      ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDW'(1);
    end else if (state_reg == FULL && out_ready) begin
      // Pop with nothing to replace it: data/id/mode keep their last values.
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      data_reg  <= '0;
      id_reg    <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      id_reg    <= id_next;
      mode_reg  <= mode_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_id    = id_reg;
  assign out_mode  = mode_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: a negedge monitor keeps a reference model of
// the arbiter and a scoreboard of expected results; directed checks in the
// main sequence pin down the literal values of each scenario.
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  localparam logic [3:0] GRAY_TBL [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDW-1:0]   id;
    logic             mode;
  } sb_item_t;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_mode;

  int n_tests = 0;
  int n_fail  = 0;

  sb_item_t         sb [$];
  int               grant_log [$];
  logic [WIDTH-1:0] out_log [$];
  bit               m_full   = 1'b0;
  int               m_ptr    = 0;
  bit               rst_prev = 1'b0;

  gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_mode  (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversions written independently of the shift/cascade form.
  function automatic logic [3:0] m_b2g(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: model of the round-robin arbiter plus scoreboard.
  always @(negedge clk) begin : mon
    int       g;
    int       idx;
    logic [NREQ-1:0] exp_ready;
    sb_item_t item;
    if (rst) begin
      check("rst_ready", 32'(req_ready), 32'd0);
      if (rst_prev) check("rst_out_valid", 32'(out_valid), 32'd0);
      sb.delete();
      m_full   = 1'b0;
      m_ptr    = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("out_valid", 32'(out_valid), 32'(m_full));
      if (out_valid && out_ready) begin
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          item = sb.pop_front();
          check("out_data", 32'(out_data), 32'(item.data));
          check("out_id", 32'(out_id), 32'(item.id));
          check("out_mode", 32'(out_mode), 32'(item.mode));
        end
        out_log.push_back(out_data);
        $display("[TB] out id=%0d mode=%0d data=%h", out_id, out_mode, out_data);
      end
      g = -1;
      exp_ready = '0;
      if (!m_full || out_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("grant", 32'(req_ready), 32'(exp_ready));
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k] && req_valid[k]) grant_log.push_back(k);
      end
      if (g >= 0) begin
        item.id   = IDW'(g);
        item.mode = req_mode[g];
        item.data = req_mode[g] ? m_g2b(req_data[g*WIDTH +: WIDTH])
                                : m_b2g(req_data[g*WIDTH +: WIDTH]);
        sb.push_back(item);
        m_full = 1'b1;
        m_ptr  = (g + 1) % NREQ;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  initial begin
    int cnt [NREQ];
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    req_mode  = '0;
    out_ready = 1'b1;

    // 1. Reset with every requester valid.
    repeat (2) tick();
    @(negedge clk);
    check("t1_rst_out_valid", 32'(out_valid), 32'd0);
    check("t1_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();

    // 2. Single conversions from requester 1.
    req_data  = {8'h00, 4'b1011, 4'h0};
    req_mode  = 4'b0000;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t2_b2g_valid", 32'(out_valid), 32'd1);
    check("t2_b2g_data", 32'(out_data), 32'b1110);
    check("t2_b2g_id", 32'(out_id), 32'd1);
    check("t2_b2g_mode", 32'(out_mode), 32'd0);
    tick();
    req_data  = {8'h00, 4'b1110, 4'h0};
    req_mode  = 4'b0010;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t2_g2b_data", 32'(out_data), 32'b1011);
    check("t2_g2b_mode", 32'(out_mode), 32'd1);
    tick();

    // 3. Exhaustive stream from requester 0, then feed the Gray codes back.
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      req_data  = {12'h000, 4'(i)};
      req_mode  = 4'b0000;
      req_valid = 4'b0001;
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    check("t3_b2g_count", 32'(out_log.size()), 32'd16);
    for (int k = 0; k < 16 && k < out_log.size(); k++)
      check("t3_b2g_table", 32'(out_log[k]), 32'(GRAY_TBL[k]));
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      req_data  = {12'h000, GRAY_TBL[i]};
      req_mode  = 4'b0001;
      req_valid = 4'b0001;
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    check("t3_g2b_count", 32'(out_log.size()), 32'd16);
    for (int k = 0; k < 16 && k < out_log.size(); k++)
      check("t3_g2b_table", 32'(out_log[k]), 32'(k));

    // 5. Backpressure: fill from req3, hold out_ready low with req2 waiting.
    out_ready = 1'b0;
    req_data  = {4'b0110, 4'b1001, 8'h00};
    req_mode  = 4'b0100;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_data", 32'(out_data), 32'b0101);
      check("t5_hold_id", 32'(out_id), 32'd3);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_release_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_next_valid", 32'(out_valid), 32'd1);
    check("t5_next_data", 32'(out_data), 32'b1110);
    check("t5_next_id", 32'(out_id), 32'd2);
    tick();

    // 4. Round-robin with all requesters valid, starting from reset.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    grant_log.delete();
    req_data  = 16'h8C35;
    req_mode  = 4'b1010;
    req_valid = 4'b1111;
    repeat (12) tick();
    check("t4_grant_count", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
    for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
      check("t4_order", 32'(grant_log[k]), 32'(k % NREQ));
      cnt[grant_log[k]]++;
    end
    for (int k = 0; k < NREQ; k++) check("t4_share", 32'(cnt[k]), 32'd3);

    // 6. Reset in the middle of the round-robin stream.
    repeat (2) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_mid_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
